crc_byte_feeder: RTL and testbench
==================================

CRC_BYTE_FEEDER -- requirements
Module: crc_byte_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of word FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  project clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port wr_en  input  1  write strobe for one word.
REQ-005 SHALL have port wr_data  input  32  write data; bytes valid per wr_size.
REQ-006 SHALL have port wr_size  input  2  00=8-bit, 01=16-bit, 10=32-bit, 11=no write.
REQ-007 SHALL have port flush  input  1  end-of-message request.
REQ-008 SHALL have port clear  input  1  synchronous drop of all queued data and flags.
REQ-009 SHALL have port out_ready  input  1  CRC engine accepts byte this cycle.
REQ-010 SHALL have port out_valid  output  1  out_byte is valid.
REQ-011 SHALL have port out_byte  output  8  next message byte to CRC engine.
REQ-012 SHALL have port done_pulse  output  1  one-cycle end-of-message strobe to CRC engine.
REQ-013 SHALL have port full  output  1  word FIFO holds DEPTH entries.
REQ-014 SHALL have port busy  output  1  FIFO non-empty, serializer loaded or flush pending.
REQ-015 SHALL have port overflow  output  1  sticky: write dropped while full.

Function
REQ-016 SHALL accept a write when wr_en=1, wr_size!=11 and full=0, storing {wr_size, wr_data} at FIFO tail.
REQ-017 SHALL ignore wr_en with wr_size=11 without any state change.
REQ-018 SHALL drop a write attempted while full=1 and set overflow; a same-cycle pop SHALL NOT make room for it.
REQ-019 SHALL use a serializer with states IDLE and SHIFT, holding one word, its byte count (1/2/4) and a 2-bit byte index.
REQ-020 SHALL, in IDLE with FIFO non-empty, pop the head into the serializer and enter SHIFT with index 0.
REQ-021 SHALL present out_byte = word bits [8*index+7 : 8*index] (LSB byte first), out_valid=1 throughout SHIFT.
REQ-022 SHALL transfer a byte only on out_valid & out_ready, then increment index; out_byte SHALL be stable while out_valid & !out_ready.
REQ-023 SHALL, on transfer of the last byte, pop the next head in the same edge if FIFO non-empty (no bubble), else return to IDLE.
REQ-024 SHALL assert first out_valid exactly 2 cycles after the edge accepting a write into an empty, idle block.
REQ-025 SHALL record flush as a pending flag; repeated flush while pending SHALL have no extra effect.
REQ-026 SHALL assert done_pulse for exactly one cycle, the cycle after the edge at which flush is pending, FIFO empty and serializer IDLE; pending SHALL clear at that edge.
REQ-027 SHALL treat flush in the same cycle as an accepted write as following that write's bytes.
REQ-028 SHALL, on clear=1, empty FIFO, return serializer to IDLE, clear pending flush and overflow; clear SHALL override a same-cycle write or flush.
REQ-029 SHALL wrap FIFO pointers modulo DEPTH, distinguishing full/empty by an extra pointer bit.

Reset
REQ-030 SHALL, while rst_n=0, force out_valid=0, out_byte=0, done_pulse=0, full=0, busy=0, overflow=0, FIFO empty, serializer IDLE, flush not pending.
REQ-031 SHALL, on reset mid-message, discard all queued bytes with no done_pulse.

Structure
REQ-032 SHALL place the wr_size encodings and serializer state encodings in a shared package crc_pkg.
REQ-033 SHALL implement the word FIFO as sub-module crc_word_fifo (parameter DEPTH, 34-bit entries).

Verification
REQ-034 SHALL cover: 32-bit write 0x44332211, out_ready=1 -> bytes 11,22,33,44 on consecutive cycles, first valid 2 cycles after write.
REQ-035 SHALL cover: writes 8-bit 0xA5 then 16-bit 0xBEEF, flush -> bytes A5,EF,BE, then done_pulse one cycle after last transfer.
REQ-036 SHALL cover: DEPTH=4, five 32-bit writes with out_ready=0 -> full=1 after four (one in serializer counts only after pop), fifth dropped, overflow=1.
REQ-037 SHALL cover: out_ready toggled 1,0,0,1 on word 0x0000C3B2 -> B2 transferred, C3 held stable two cycles then transferred.
REQ-038 SHALL cover: flush with block idle and empty -> done_pulse high exactly one cycle, busy low after.
REQ-039 SHALL cover: rst_n low mid-word and clear mid-word -> out_valid=0, busy=0, no done_pulse, next write restarts at byte 0.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared encodings for the CRC byte feeder: write-size codes, serializer states
// and the layout of one queued word.
package crc_pkg;

  localparam int WORD_W  = 32;
  localparam int ENTRY_W = WORD_W + 2;

  typedef enum logic [1:0] {
    SIZE_8    = 2'b00,
    SIZE_16   = 2'b01,
    SIZE_32   = 2'b10,
    SIZE_NONE = 2'b11
  } wr_size_e;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_e;

  typedef struct packed {
    logic [1:0]        size;
    logic [WORD_W-1:0] data;
  } fifo_entry_t;

  // Index of the final byte of a word: 0, 1 or 3 for 1, 2 or 4 valid bytes.
  function automatic logic [1:0] last_index(input logic [1:0] size);
    case (size)
      SIZE_8:  return 2'd0;
      SIZE_16: return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/crc_word_fifo.sv
// Word FIFO for the CRC byte feeder; pointers carry one extra wrap bit so
// full and empty are told apart without a separate counter.
module crc_word_fifo
  import crc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] push_data_i,
  input  logic               pop_i,
  output logic [ENTRY_W-1:0] head_o,
  output logic               empty_o,
  output logic               full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]        wr_ptr_q, rd_ptr_q;
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/crc_byte_feeder.sv
// Queues 8/16/32-bit writes and feeds them LSB-first, one byte per handshake,
// to a CRC engine, with an end-of-message strobe once all bytes have gone out.
module crc_byte_feeder
  import crc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic [1:0]  wr_size,
  input  logic        flush,
  input  logic        clear,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [7:0]  out_byte,
  output logic        done_pulse,
  output logic        full,
  output logic        busy,
  output logic        overflow
);

  ser_state_e  state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  last_q, last_d;
  logic [1:0]  idx_q, idx_d;
  logic        avail_q, pending_q, overflow_q, done_q;

  logic        wr_req, push, pop, fifo_empty, fifo_full, xfer, fire;
  fifo_entry_t wr_entry, head;

  assign wr_req   = wr_en && (wr_size != SIZE_NONE);
  assign push     = wr_req && !fifo_full && !clear;
  assign wr_entry = '{size: wr_size, data: wr_data};
  assign xfer     = (state_q == SER_SHIFT) && out_ready;
  assign fire     = pending_q && fifo_empty && (state_q == SER_IDLE) && !clear;

  crc_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (clear),
    .push_i     (push),
    .push_data_i(wr_entry),
    .pop_i      (pop),
    .head_o     (head),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SER_IDLE;
      word_q     <= '0;
      last_q     <= '0;
      idx_q      <= '0;
      avail_q    <= 1'b0;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      last_q     <= last_d;
      idx_q      <= idx_d;
      // An idle serializer sees a newly landed word one cycle after it was written.
      avail_q    <= !clear && !fifo_empty;
      pending_q  <= !clear && !fire && (pending_q || flush);
      overflow_q <= !clear && (overflow_q || (wr_req && fifo_full));
      done_q     <= fire;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    last_d  = last_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    if (clear) begin
      state_d = SER_IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        SER_IDLE: begin
          if (avail_q && !fifo_empty) begin
            pop     = 1'b1;
            state_d = SER_SHIFT;
            word_d  = head.data;
            last_d  = last_index(head.size);
            idx_d   = '0;
          end
        end
        SER_SHIFT: begin
          if (xfer && (idx_q == last_q)) begin
            if (!fifo_empty) begin
              pop     = 1'b1;
              word_d  = head.data;
              last_d  = last_index(head.size);
              idx_d   = '0;
            end else begin
              state_d = SER_IDLE;
            end
          end else if (xfer) begin
            idx_d = idx_q + 2'd1;
          end
        end
        default: state_d = SER_IDLE;
      endcase
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_byte  = '0;
    if (state_q == SER_SHIFT) begin
      out_valid = 1'b1;
      out_byte  = word_q[{idx_q, 3'b000} +: 8];
    end
  end

  assign done_pulse = done_q;
  assign full       = fifo_full;
  assign overflow   = overflow_q;
  assign busy       = !fifo_empty || (state_q == SER_SHIFT) || pending_q;

endmodule

// File: tb/tb_crc_byte_feeder.sv
// Scoreboard bench for crc_byte_feeder: stimulus queues expected bytes, a
// negedge monitor checks every handshake and every done_pulse.
module tb_crc_byte_feeder;
  import crc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, wr_en, flush, clear, out_ready;
  logic [31:0] wr_data;
  logic [1:0]  wr_size;
  logic        out_valid, done_pulse, full, busy, overflow;
  logic [7:0]  out_byte;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_xfer_cyc = 0;
  int done_cyc = 0;
  logic [7:0] exp_q [$];

  crc_byte_feeder #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_size   (wr_size),
    .flush     (flush),
    .clear     (clear),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_byte  (out_byte),
    .done_pulse(done_pulse),
    .full      (full),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a byte moves when valid & ready are seen mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_byte", {24'h0, out_byte}, 32'hxxxx_xxxx);
        else check("byte", {24'h0, out_byte}, {24'h0, exp_q.pop_front()});
        last_xfer_cyc = cyc;
      end
      if (done_pulse) begin
        check("done_after_all_bytes", exp_q.size(), 0);
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_bytes(input logic [1:0] sz, input logic [31:0] d);
    int n;
    n = (sz == SIZE_8) ? 1 : (sz == SIZE_16) ? 2 : 4;
    for (int i = 0; i < n; i++) exp_q.push_back(d[8*i +: 8]);
  endtask

  task automatic write(input logic [1:0] sz, input logic [31:0] d, input logic fl);
    wr_en = 1'b1; wr_size = sz; wr_data = d; flush = fl;
    tick();
    wr_en = 1'b0; wr_size = SIZE_NONE; flush = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check(name, out_valid, 1'b1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 100) begin tick(); n++; end
    check(name, busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0;
    logic [31:0] words [6];
    words = '{32'hA3A2A1A0, 32'hB3B2B1B0, 32'hC3C2C1C0, 32'hD3D2D1D0, 32'hE3E2E1E0, 32'hF3F2F1F0};
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; wr_size = SIZE_NONE;
    flush = 1'b0; clear = 1'b0; out_ready = 1'b1;
    #13;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_byte", out_byte, 0);
    check("rst_done", done_pulse, 0);
    check("rst_full", full, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();

    // 32-bit word: first valid two cycles after the accepting edge, then four back-to-back bytes.
    expect_bytes(SIZE_32, 32'h44332211);
    write(SIZE_32, 32'h44332211, 1'b0);
    n = 0;
    while (!out_valid && n < 8) begin tick(); n++; end
    check("first_valid_latency", n, 2);
    n = 0;
    while (out_valid && n < 8) begin tick(); n++; end
    check("burst_cycles", n, 4);
    wait_idle("idle_after_word");

    // 8-bit then 16-bit with flush on the second write.
    d0 = done_cnt;
    expect_bytes(SIZE_8, 32'h000000A5);
    write(SIZE_8, 32'h000000A5, 1'b0);
    expect_bytes(SIZE_16, 32'h0000BEEF);
    write(SIZE_16, 32'h0000BEEF, 1'b1);
    n = 0;
    while (done_cnt == d0 && n < 20) begin tick(); n++; end
    tick(); tick();
    check("msg_done_count", done_cnt, d0 + 1);
    check("done_after_last_xfer", done_cyc - last_xfer_cyc, 2);
    check("msg_busy_after_done", busy, 0);

    // Backpressure 1,0,0,1 on 0x0000C3B2.
    out_ready = 1'b0;
    expect_bytes(SIZE_16, 32'h0000C3B2);
    write(SIZE_16, 32'h0000C3B2, 1'b0);
    wait_valid("stall_valid");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("stall_valid_held", out_valid, 1);
      check("stall_byte_held", out_byte, 8'hC3);
    end
    tick();
    out_ready = 1'b1;
    wait_idle("idle_after_stall");

    // Fill: one word in the serializer, four in the FIFO, next write dropped.
    out_ready = 1'b0;
    expect_bytes(SIZE_32, words[0]);
    write(SIZE_32, words[0], 1'b0);
    wait_valid("fill_first_loaded");
    for (int i = 1; i < 6; i++) begin
      if (i < 5) expect_bytes(SIZE_32, words[i]);
      write(SIZE_32, words[i], 1'b0);
      check($sformatf("full_after_write%0d", i), full, (i >= 4));
      check($sformatf("overflow_after_write%0d", i), overflow, (i == 5));
    end
    out_ready = 1'b1;
    wait_idle("idle_after_fill");
    check("overflow_sticky", overflow, 1);
    clear = 1'b1; tick(); clear = 1'b0;
    check("overflow_cleared", overflow, 0);

    // wr_size=11 is ignored; a flush held two cycles gives one done_pulse.
    write(SIZE_NONE, 32'hFFFFFFFF, 1'b0);
    tick();
    check("nowrite_busy", busy, 0);
    check("nowrite_valid", out_valid, 0);
    d0 = done_cnt;
    flush = 1'b1;
    tick();
    check("flush_pending_busy", busy, 1);
    tick();
    flush = 1'b0;
    check("flush_done_high", done_pulse, 1);
    check("flush_busy_low", busy, 0);
    tick(); tick();
    check("flush_done_once", done_cnt, d0 + 1);
    check("flush_done_low", done_pulse, 0);

    // Reset mid-word with a pending flush: nothing further, restart at byte 0.
    out_ready = 1'b0;
    exp_q.push_back(8'h78);
    write(SIZE_32, 32'h12345678, 1'b1);
    wait_valid("rst_mid_valid");
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid_low", out_valid, 0);
    check("rst_mid_busy_low", busy, 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) tick();
    check("rst_mid_no_done", done_cnt, d0);
    expect_bytes(SIZE_32, 32'hDDCCBBAA);
    write(SIZE_32, 32'hDDCCBBAA, 1'b0);
    wait_idle("idle_after_rst_restart");

    // Clear mid-word overrides the pending flush.
    out_ready = 1'b0;
    exp_q.push_back(8'h21);
    write(SIZE_32, 32'h87654321, 1'b1);
    wait_valid("clr_mid_valid");
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    d0 = done_cnt;
    clear = 1'b1; tick(); clear = 1'b0;
    check("clr_mid_valid_low", out_valid, 0);
    check("clr_mid_busy_low", busy, 0);
    repeat (4) tick();
    check("clr_mid_no_done", done_cnt, d0);
    out_ready = 1'b1;
    expect_bytes(SIZE_16, 32'h00009988);
    write(SIZE_16, 32'h00009988, 1'b0);
    wait_idle("idle_after_clr_restart");

    tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
